controller_sequencer: RTL and testbench

//  SAP-1 control unit; consumes instruction_decoder flags (lda/add/sub/out/hlt), drives full control word.
//  One-hot ring counter T1..T6 (fetch T1-T3, execute T4-T6); HALTED state on hlt.

---
 rtl/controller_sequencer_pkg.sv | 37 +++
 rtl/controller_sequencer_ring_counter.sv | 29 ++
 rtl/controller_sequencer.sv | 123 ++++++++++++
 tb/tb_controller_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/controller_sequencer_pkg.sv
// Shared types for the SAP-1 control unit: ring-state indices, the control word and its idle value.
package sap1_pkg;

    typedef enum logic [2:0] {
        T1     = 3'd0,
        T2     = 3'd1,
        T3     = 3'd2,
        T4     = 3'd3,
        T5     = 3'd4,
        T6     = 3'd5,
        HALTED = 3'd6
    } t_state_e;

    typedef struct packed {
        logic cp;
        logic ep;
        logic ea;
        logic su;
        logic eu;
        logic lm_bar;
        logic ce_bar;
        logic li_bar;
        logic ei_bar;
        logic la_bar;
        logic lb_bar;
        logic lo_bar;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_IDLE = '{
        cp: 1'b0, ep: 1'b0, ea: 1'b0, su: 1'b0, eu: 1'b0,
        lm_bar: 1'b1, ce_bar: 1'b1, li_bar: 1'b1, ei_bar: 1'b1,
        la_bar: 1'b1, lb_bar: 1'b1, lo_bar: 1'b1
    };

    localparam int NUM_T_STATES = 6;

endpackage

// File: rtl/controller_sequencer_ring_counter.sv
// One-hot T-state ring: async clear and sync park both land on T1; wrap jumps back to T1 early.
module ring_counter #(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         clear_bar,
    input  logic         park,
    input  logic         wrap,
    input  logic         hold,
    output logic [N-1:0] ring
);

    localparam logic [N-1:0] FIRST = {{(N-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge clear_bar) begin
        if (!clear_bar) begin
            ring <= FIRST;
        end else if (park) begin
            ring <= FIRST;
        end else if (hold) begin
            ring <= ring;
        end else if (wrap) begin
            ring <= FIRST;
        end else begin
            ring <= {ring[N-2:0], ring[N-1]};
        end
    end

endmodule

// File: rtl/controller_sequencer.sv
// SAP-1 control unit: ring counter plus HALTED flop; the control word is a pure decode of state and flags.
module controller_sequencer
    import sap1_pkg::*;
#(
    parameter int NUM_T_STATES = sap1_pkg::NUM_T_STATES,
    parameter bit SKIP_NOP     = 1'b0
) (
    input  logic       clk,
    input  logic       clear_bar,
    input  logic       run_not_prog,
    input  logic       lda,
    input  logic       add,
    input  logic       sub,
    input  logic       out,
    input  logic       hlt,
    output logic       Cp,
    output logic       Ep,
    output logic       Ea,
    output logic       Su,
    output logic       Eu,
    output logic       Lm_bar,
    output logic       ce_bar,
    output logic       Li_bar,
    output logic       Ei_bar,
    output logic       La_bar,
    output logic       Lb_bar,
    output logic       Lo_bar,
    output logic [5:0] t_state,
    output logic       halted
);

    if (NUM_T_STATES != 6) begin : g_bad_t_states
        $error("controller_sequencer: NUM_T_STATES must be 6");
    end

    logic [5:0] ring;
    logic       sel_hlt, sel_out, sel_sub, sel_add, sel_lda;
    logic       active, wrap, halt_now;
    ctrl_word_t cw;

    // Flag priority: hlt > out > sub > add > lda.
    assign sel_hlt = hlt;
    assign sel_out = out & ~hlt;
    assign sel_sub = sub & ~out & ~hlt;
    assign sel_add = add & ~sub & ~out & ~hlt;
    assign sel_lda = lda & ~add & ~sub & ~out & ~hlt;

    assign active   = clear_bar & run_not_prog & ~halted;
    assign halt_now = active & ring[T4] & sel_hlt;
    assign wrap     = SKIP_NOP & active & ((ring[T5] & sel_lda) | (ring[T4] & sel_out));

    ring_counter #(.N(6)) u_ring (
        .clk       (clk),
        .clear_bar (clear_bar),
        .park      (~run_not_prog & ~halted),
        .wrap      (wrap),
        .hold      (halted),
        .ring      (ring)
    );

    always_ff @(posedge clk or negedge clear_bar) begin
        if (!clear_bar) begin
            halted <= 1'b0;
        end else if (halt_now) begin
            halted <= 1'b1;
        end
    end

    always_comb begin
        cw = CTRL_IDLE;
        if (active) begin
            if (ring[T1]) begin
                cw.ep     = 1'b1;
                cw.lm_bar = 1'b0;
            end
            if (ring[T2]) begin
                cw.cp = 1'b1;
            end
            if (ring[T3]) begin
                cw.ce_bar = 1'b0;
                cw.li_bar = 1'b0;
            end
            if (ring[T4]) begin
                if (sel_out) begin
                    cw.ea     = 1'b1;
                    cw.lo_bar = 1'b0;
                end else if (sel_lda | sel_add | sel_sub) begin
                    cw.ei_bar = 1'b0;
                    cw.lm_bar = 1'b0;
                end
            end
            if (ring[T5]) begin
                if (sel_lda) begin
                    cw.ce_bar = 1'b0;
                    cw.la_bar = 1'b0;
                end else if (sel_add | sel_sub) begin
                    cw.ce_bar = 1'b0;
                    cw.lb_bar = 1'b0;
                end
            end
            if (ring[T6] && (sel_add | sel_sub)) begin
                cw.eu     = 1'b1;
                cw.su     = sel_sub;
                cw.la_bar = 1'b0;
            end
        end
    end

    assign Cp      = cw.cp;
    assign Ep      = cw.ep;
    assign Ea      = cw.ea;
    assign Su      = cw.su;
    assign Eu      = cw.eu;
    assign Lm_bar  = cw.lm_bar;
    assign ce_bar  = cw.ce_bar;
    assign Li_bar  = cw.li_bar;
    assign Ei_bar  = cw.ei_bar;
    assign La_bar  = cw.la_bar;
    assign Lb_bar  = cw.lb_bar;
    assign Lo_bar  = cw.lo_bar;
    assign t_state = halted ? 6'b000000 : ring;

endmodule

// File: tb/tb_controller_sequencer.sv
// Bench for controller_sequencer: fixed-length and SKIP_NOP instances driven in lockstep against a step/opcode model.
module tb_controller_sequencer;

    logic clk = 1'b0;
    logic clear_bar = 1'b0;
    logic run = 1'b1;
    logic lda = 1'b0, add = 1'b0, sub = 1'b0, out = 1'b0, hlt = 1'b0;

    // Control word order in this bench: {cp,ep,ea,su,eu,lm,ce,li,ei,la,lb,lo}
    localparam logic [11:0] IDLE = 12'b00000_1111111;

    logic        cp0, ep0, ea0, su0, eu0, lm0, ce0, li0, ei0, la0, lb0, lo0, h0;
    logic        cp1, ep1, ea1, su1, eu1, lm1, ce1, li1, ei1, la1, lb1, lo1, h1;
    logic [5:0]  ts0, ts1;
    logic [11:0] act_cw [2];
    logic [5:0]  act_ts [2];
    logic        act_h  [2];

    int tests_run = 0;
    int tests_failed = 0;
    int m_step [2];
    bit m_halt [2];
    bit check_on = 1'b0;

    always #5 clk = ~clk;

    controller_sequencer #(.NUM_T_STATES(6), .SKIP_NOP(1'b0)) dut0 (
        .clk(clk), .clear_bar(clear_bar), .run_not_prog(run),
        .lda(lda), .add(add), .sub(sub), .out(out), .hlt(hlt),
        .Cp(cp0), .Ep(ep0), .Ea(ea0), .Su(su0), .Eu(eu0),
        .Lm_bar(lm0), .ce_bar(ce0), .Li_bar(li0), .Ei_bar(ei0),
        .La_bar(la0), .Lb_bar(lb0), .Lo_bar(lo0),
        .t_state(ts0), .halted(h0)
    );

    controller_sequencer #(.NUM_T_STATES(6), .SKIP_NOP(1'b1)) dut1 (
        .clk(clk), .clear_bar(clear_bar), .run_not_prog(run),
        .lda(lda), .add(add), .sub(sub), .out(out), .hlt(hlt),
        .Cp(cp1), .Ep(ep1), .Ea(ea1), .Su(su1), .Eu(eu1),
        .Lm_bar(lm1), .ce_bar(ce1), .Li_bar(li1), .Ei_bar(ei1),
        .La_bar(la1), .Lb_bar(lb1), .Lo_bar(lo1),
        .t_state(ts1), .halted(h1)
    );

    assign act_cw[0] = {cp0, ep0, ea0, su0, eu0, lm0, ce0, li0, ei0, la0, lb0, lo0};
    assign act_cw[1] = {cp1, ep1, ea1, su1, eu1, lm1, ce1, li1, ei1, la1, lb1, lo1};
    assign act_ts[0] = ts0;
    assign act_ts[1] = ts1;
    assign act_h[0]  = h0;
    assign act_h[1]  = h1;

    // 0 none, 1 lda, 2 add, 3 sub, 4 out, 5 hlt
    function automatic int cur_op();
        if (hlt) return 5;
        if (out) return 4;
        if (sub) return 3;
        if (add) return 2;
        if (lda) return 1;
        return 0;
    endfunction

    function automatic logic [11:0] exp_cw(int step, bit halt_s);
        logic cp, ep, ea, su, eu, lm, ce, li, ei, la, lb, lo;
        int op;
        op = cur_op();
        {cp, ep, ea, su, eu, lm, ce, li, ei, la, lb, lo} = IDLE;
        if (!clear_bar || halt_s || !run) return IDLE;
        case (step)
            1: begin ep = 1; lm = 0; end
            2: cp = 1;
            3: begin ce = 0; li = 0; end
            4: if (op == 4) begin ea = 1; lo = 0; end
               else if (op >= 1 && op <= 3) begin ei = 0; lm = 0; end
            5: if (op == 1) begin ce = 0; la = 0; end
               else if (op == 2 || op == 3) begin ce = 0; lb = 0; end
            6: if (op == 2 || op == 3) begin eu = 1; la = 0; su = (op == 3); end
            default: ;
        endcase
        return {cp, ep, ea, su, eu, lm, ce, li, ei, la, lb, lo};
    endfunction

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_step[i] = 1;
            m_halt[i] = 0;
        end
    end

    always @(posedge clk or negedge clear_bar) begin
        for (int i = 0; i < 2; i++) begin
            if (!clear_bar) begin
                m_step[i] = 1;
                m_halt[i] = 0;
            end else if (m_halt[i]) begin
                m_halt[i] = 1;
            end else if (!run) begin
                m_step[i] = 1;
            end else if (m_step[i] == 4 && cur_op() == 5) begin
                m_halt[i] = 1;
            end else if (i == 1 && ((m_step[i] == 5 && cur_op() == 1) ||
                                    (m_step[i] == 4 && cur_op() == 4))) begin
                m_step[i] = 1;
            end else begin
                m_step[i] = (m_step[i] % 6) + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (check_on) begin
            for (int i = 0; i < 2; i++) begin
                logic [18:0] exp_v, act_v;
                exp_v = {(m_halt[i] ? 6'd0 : 6'(1 << (m_step[i] - 1))), m_halt[i], exp_cw(m_step[i], m_halt[i])};
                act_v = {act_ts[i], act_h[i], act_cw[i]};
                tests_run++;
                if (act_v !== exp_v) begin
                    tests_failed++;
                    $display("FAIL model_dut%0d t=%0t got ts/h/cw=%b required %b", i, $time, act_v, exp_v);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s t=%0t got %0h required %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear_bar = 1'b0;
        #1;
        clear_bar = 1'b1;
    endtask

    initial begin
        int cp_seen;
        // Reset held across edges
        tick(2);
        chk("reset_ts", ts0, 6'b000001);
        chk("reset_halted", h0, 1'b0);
        chk("reset_idle", act_cw[0], IDLE);
        check_on = 1'b1;

        // LDA, full six states
        lda = 1'b1;
        clear_bar = 1'b1;
        #1;
        chk("t1_ep_lm", {ep0, lm0}, 2'b10);
        tick(1); chk("t2_cp", cp0, 1'b1);
        tick(1); chk("t3_ce_li", {ce0, li0}, 2'b00);
        tick(1); chk("t4_ei_lm", {ei0, lm0}, 2'b00);
        tick(1); chk("t5_lda_ce_la", {ce0, la0}, 2'b00);
        tick(1); chk("t6_lda_idle", act_cw[0], IDLE);
        tick(1); chk("t1_again", ts0, 6'b000001);

        // ADD then SUB
        pulse_clear();
        lda = 1'b0; add = 1'b1;
        tick(4); chk("add_t5_lb", {ce0, lb0}, 2'b00);
        tick(1); chk("add_t6", {su0, eu0, la0}, 3'b010);
        tick(1); add = 1'b0; sub = 1'b1;
        tick(4); chk("sub_t5_lb", {ce0, lb0}, 2'b00);
        tick(1); chk("sub_t6", {su0, eu0, la0}, 3'b110);
        sub = 1'b0;

        // HLT at T4, run toggling ignored while halted
        pulse_clear();
        hlt = 1'b1;
        tick(3); chk("hlt_t4_idle", act_cw[0], IDLE);
        tick(1); chk("halted_flag", h0, 1'b1);
        chk("halted_ts", ts0, 6'b000000);
        cp_seen = 0;
        for (int k = 0; k < 20; k++) begin
            run = (k >= 5 && k < 9) ? 1'b0 : 1'b1;
            tick(1);
            if (cp0 || cp1) cp_seen++;
        end
        chk("halted_no_cp", cp_seen, 0);
        hlt = 1'b0;
        pulse_clear();
        chk("unhalt_ts", ts0, 6'b000001);
        chk("unhalt_h", h0, 1'b0);

        // run_not_prog drop during T5
        lda = 1'b1;
        tick(4); chk("pre_park_t5", ts0, 6'b010000);
        run = 1'b0;
        #1;
        chk("park_idle_now", act_cw[0], IDLE);
        tick(1); chk("park_t1", ts0, 6'b000001);
        tick(5); chk("parked_t1", ts0, 6'b000001);
        run = 1'b1;
        #1;
        chk("resume_ep", ep0, 1'b1);
        tick(1); chk("resume_t2", ts0, 6'b000010);

        // SKIP_NOP instance: OUT is 4 states, LDA is 5
        pulse_clear();
        lda = 1'b0; out = 1'b1;
        tick(3); chk("skip_out_t4", {ea1, lo1}, 2'b10);
        tick(1); chk("skip_out_wrap", ts1, 6'b000001);
        out = 1'b0; lda = 1'b1;
        tick(4); chk("skip_lda_t5", ts1, 6'b010000);
        tick(1); chk("skip_lda_wrap", ts1, 6'b000001);

        // Async clear mid-T3, then lda+add priority
        pulse_clear();
        add = 1'b1;
        tick(2); chk("pre_clear_t3", ts0, 6'b000100);
        #2;
        clear_bar = 1'b0;
        #1;
        chk("async_clear_ts", ts0, 6'b000001);
        chk("async_clear_idle", act_cw[0], IDLE);
        clear_bar = 1'b1;
        tick(3); chk("prio_t4", {ei0, lm0}, 2'b00);
        tick(1); chk("prio_t5", {ce0, la0, lb0}, 3'b010);
        tick(1); chk("prio_t6", {eu0, la0}, 2'b10);
        tick(1);

        check_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
